// File: rtl/alu_harness_pkg.sv
// Shared constants for the switch-driven ALU harness front end.
package alu_harness_pkg;

    // Entry-sequence state encoding; 2'd3 is unused and recovers to WAIT_X.
    localparam logic [1:0] ST_WAIT_X  = 2'd0;
    localparam logic [1:0] ST_WAIT_Y  = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    // 10 ms of stable button level at a 50 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises an asynchronous active-low button, debounces it and emits a
// single-cycle pulse on each debounced press (1 -> 0 transition).
module button_debouncer
    import alu_harness_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: two-stage synchroniser, stability counter, falling-edge pulse.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = {CNT_W{1'b0}};
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Level has differed for DEBOUNCE_CYCLES cycles: accept it.
                level_d = sync2_q;
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        // Only the released-to-pressed transition produces a pulse.
        press_d = level_q & ~level_d;
    end

    // State flops; reset assumes the button is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_entry_sequencer.sv
// Operand entry front end: debounced button presses step X -> Y -> DONE,
// capturing the switch nibble into held operand registers.
module operand_entry_sequencer
    import alu_harness_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic             load_x,
    output logic             load_y,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             operands_valid,
    output logic [1:0]       state
);

    logic             press;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             load_x_q, load_x_d;
    logic             load_y_q, load_y_d;
    logic             valid_q, valid_d;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debouncer (
        .clock (clock),
        .reset (reset),
        .key_n (key_n),
        .press (press)
    );

    // Entry sequencing: clear wins over a coincident press, which is dropped.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        load_x_d = 1'b0;
        load_y_d = 1'b0;
        valid_d  = valid_q;
        if (clear) begin
            state_d = ST_WAIT_X;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_X: begin
                    if (press) begin
                        x_d      = data_in;
                        load_x_d = 1'b1;
                        state_d  = ST_WAIT_Y;
                    end else begin
                        state_d = ST_WAIT_X;
                    end
                end
                ST_WAIT_Y: begin
                    if (press) begin
                        y_d      = data_in;
                        load_y_d = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_WAIT_Y;
                    end
                end
                ST_DONE: begin
                    // A press here starts a new pair; old Y stays until reloaded.
                    if (press) begin
                        x_d      = data_in;
                        load_x_d = 1'b1;
                        valid_d  = 1'b0;
                        state_d  = ST_WAIT_Y;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    // Unused encoding: return to a known start within one clock.
                    state_d = ST_WAIT_X;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Registered sequencer state and outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_WAIT_X;
            x_q      <= {WIDTH{1'b0}};
            y_q      <= {WIDTH{1'b0}};
            load_x_q <= 1'b0;
            load_y_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            load_x_q <= load_x_d;
            load_y_q <= load_y_d;
            valid_q  <= valid_d;
        end
    end

    assign state          = state_q;
    assign x_out          = x_q;
    assign y_out          = y_q;
    assign load_x         = load_x_q;
    assign load_y         = load_y_q;
    assign operands_valid = valid_q;

endmodule
